spi_slave_reg_ctrl: RTL and testbench
=====================================

Name: spi_slave_reg_ctrl

Overview:
- SPI slave-side register controller clocked directly by the bus SCLK.
- Decodes fixed 32-bit MSB-first frames from the SPI master into reads and writes of a small configuration register bank.
- Drives read data back on MISO and exports the register contents to the fabric.
- Acts as the configuration and arbitration point between the master's frames and the on-chip register resource.

Parameters:
- NREGS, 4: number of writable 24-bit registers (1..64), at addresses 0..NREGS-1.
- RESET_VAL, 24'h000000: reset value of every register.
- STATUS_ADDR, 7'h7F: read-only address that returns status_in; must be >= NREGS.

Ports:
- rst  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock; all state advances on the rising edge.
- CS  input  1  chip select, active-low; high asynchronously aborts and clears the frame state.
- MOSI  input  1  serial data from master, sampled on the rising SCLK edge.
- MISO  output  1  serial data to master, updated on the rising SCLK edge.
- status_in  input  24  read-only status word, sampled at the 8th edge of a read of STATUS_ADDR.
- regs_out  output  NREGS*24  flattened register bank; reg i occupies bits [24*i+23:24*i].
- wr_toggle  output  1  inverts once per committed write (CDC-friendly event).
- last_addr  output  7  address of the most recent committed write.

Behaviour:
- Reset (rst low, async):
  - all regs = RESET_VAL; MISO=0; wr_toggle=0; last_addr=0; bit counter=0; shift registers=0.
- Frame format, counted from the first rising SCLK edge after CS falls:
  - bit31 = WR (1=write, 0=read); bits30:24 = ADDR[6:0]; bits23:0 = DATA.
- Bit counter:
  - 6-bit, incremented on each rising SCLK edge while CS is low.
  - Saturates at 32; edges 33 and beyond are ignored (no shift, no commit, MISO holds 0).
- CS high: asynchronously clears the bit counter, command register, receive shift register and MISO shift register. Registers, wr_toggle and last_addr are untouched.
- State machine:
  - CMD: edges 1..8 shift MOSI into the command register; MISO=0.
  - DATA: edges 9..32.
  - DONE: counter = 32.
  - Transitions: CMD->DATA on edge 8; DATA->DONE on edge 32; any state -> CMD when CS is high.
- Read (WR=0):
  - On edge 8, load the MISO shift register with:
    - reg[ADDR] if ADDR < NREGS;
    - status_in if ADDR == STATUS_ADDR;
    - 24'h000000 otherwise.
  - MISO = shift[23] immediately after edge 8; each edge 9..31 shifts left by one, so MISO presents data bit 23-k after edge 8+k.
  - After edge 32, MISO=0.
- Write (WR=1):
  - MISO stays 0 for the whole frame.
  - DATA is shifted in on edges 9..32.
  - On edge 32, if ADDR < NREGS: reg[ADDR] <= DATA, last_addr <= ADDR, wr_toggle inverts (all in the same edge).
  - Writes to ADDR >= NREGS, including STATUS_ADDR, are discarded with no toggle.
- Aborted frame (CS rises before edge 32): no commit. The next frame starts at CMD.
- Back-to-back frames require CS to return high between them. Without a CS-high gap, edges after 32 are ignored as above.
- Reset mid-frame: frame aborted, registers return to RESET_VAL.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- When defined:
  - Adds output frame_err (1 bit), with reset value 0.
  - frame_err is set to 1 when CS rises with bit counter in 1..31, or when a rising edge arrives with counter already at 32.
  - It is sticky and cleared only by a committed write of any data to STATUS_ADDR. That write is accepted solely for this purpose: no wr_toggle, last_addr unchanged.
  - A read of STATUS_ADDR returns {frame_err, status_in[22:0]}.
- When not defined: no frame_err port; STATUS_ADDR reads return status_in unchanged; all writes to STATUS_ADDR are discarded.

Test Plan:
- Reset then read: pulse rst low; read addr 0 (frame 32'h00000000) -> MISO stream 24'h000000, regs_out all zero, wr_toggle=0.
- Write then read back: write frame 32'h81ABCDEF -> reg1=24'hABCDEF after edge 32, wr_toggle=1, last_addr=1. Then read frame 32'h01000000 -> MISO bits after edges 8..31 = 24'hABCDEF.
- Status read: status_in=24'h5A5A5A, frame 32'h7F000000 -> MISO returns 24'h5A5A5A. A write frame 32'hFF123456 changes nothing and leaves wr_toggle unchanged.
- Out-of-range address: write 32'h90FFFFFF (addr 0x10, NREGS=4) -> no register changes, no toggle. A read of the same address returns 24'h000000.
- Abort: write 32'h82112233 with CS raised after 20 edges -> reg2 unchanged, no toggle. The next full frame 32'h82112233 commits reg2=24'h112233. With SPI_FRAME_ERR_EN, frame_err=1 after the abort; a write to 7'h7F clears it to 0.
- Async reset mid-frame: rst low at edge 15 of a write to reg0 -> regs=RESET_VAL, MISO=0. The first frame after rst returns high decodes correctly.

Source files
------------

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: SCLK-clocked SPI slave decoding 32-bit frames into register bank reads/writes.
// Define SPI_FRAME_ERR_EN to add the sticky frame_err output, cleared by writing STATUS_ADDR.
module spi_slave_reg_ctrl #(
    parameter int          NREGS       = 4,
    parameter logic [23:0] RESET_VAL   = 24'h000000,
    parameter logic [6:0]  STATUS_ADDR = 7'h7F
) (
    input  logic                rst,
    input  logic                SCLK,
    input  logic                CS,
    input  logic                MOSI,
    output logic                MISO,
    input  logic [23:0]         status_in,
    output logic [NREGS*24-1:0] regs_out,
    output logic                wr_toggle,
    output logic [6:0]          last_addr
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                frame_err
`endif
);
    typedef enum logic [1:0] {S_CMD, S_DATA, S_DONE} state_t;
    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [7:0]  r_cmd;
    logic [22:0] r_rx;
    logic [23:0] r_tx;
    logic [23:0] r_regs [NREGS];
    logic [7:0]  w_cmd;
    logic [23:0] w_data, w_rdata, w_status;
    logic        w_frm_rst_n, w_commit, w_in_range;

    assign w_frm_rst_n = rst & ~CS;
    assign w_cmd       = {r_cmd[6:0], MOSI};
    assign w_data      = {r_rx, MOSI};
    assign w_commit    = (r_state == S_DATA) && (r_cnt == 6'd31) && r_cmd[7];
    assign w_in_range  = r_cmd[6:0] < 7'(NREGS);
    assign MISO        = r_tx[23];

    always_comb begin
        w_rdata = (w_cmd[6:0] == STATUS_ADDR) ? w_status : 24'h000000;
        for (int i = 0; i < NREGS; i++)
            if (w_cmd[6:0] == 7'(i)) w_rdata = r_regs[i];
    end

    // CS high acts as an async clear of everything that belongs to the current frame
    always_ff @(posedge SCLK or negedge w_frm_rst_n) begin
        if (!w_frm_rst_n) begin
            r_state <= S_CMD;
            r_cnt   <= 6'd0;
            r_cmd   <= 8'd0;
            r_rx    <= 23'd0;
            r_tx    <= 24'd0;
        end else begin
            if (r_state != S_DONE) r_cnt <= r_cnt + 6'd1;
            if (r_state == S_CMD) begin
                r_cmd <= w_cmd;
                if (r_cnt == 6'd7) begin
                    r_state <= S_DATA;
                    r_tx    <= w_cmd[7] ? 24'h000000 : w_rdata;
                end
            end else if (r_state == S_DATA) begin
                r_rx <= w_data[22:0];
                r_tx <= {r_tx[22:0], 1'b0};
                if (r_cnt == 6'd31) r_state <= S_DONE;
            end
        end
    end

    always_ff @(posedge SCLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
            wr_toggle <= 1'b0;
            last_addr <= 7'd0;
        end else if (w_commit && w_in_range) begin
            for (int i = 0; i < NREGS; i++)
                if (r_cmd[6:0] == 7'(i)) r_regs[i] <= w_data;
            wr_toggle <= ~wr_toggle;
            last_addr <= r_cmd[6:0];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_out
        assign regs_out[24*g +: 24] = r_regs[g];
    end

`ifdef SPI_FRAME_ERR_EN
    // Error flag spans two clock domains: set/clear owners each flip their own bit, flag = XOR
    logic r_err_s, r_err_c, w_frame_err, w_unused;
    assign w_frame_err = r_err_s ^ r_err_c;
    assign frame_err   = w_frame_err;
    assign w_status    = {w_frame_err, status_in[22:0]};
    assign w_unused    = status_in[23];

    always_ff @(posedge CS or negedge rst) begin
        if (!rst) r_err_s <= 1'b0;
        else if (!w_frame_err && r_cnt != 6'd0 && r_cnt != 6'd32) r_err_s <= ~r_err_s;
    end

    always_ff @(posedge SCLK or negedge rst) begin
        if (!rst) r_err_c <= 1'b0;
        else if (w_commit && r_cmd[6:0] == STATUS_ADDR) r_err_c <= r_err_s;
        else if (r_state == S_DONE) r_err_c <= ~r_err_s;
    end
`else
    assign w_status = status_in;
`endif
endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// tb_spi_slave_reg_ctrl: randomized SPI frames checked against a frame-level register model.
module tb_spi_slave_reg_ctrl;
    localparam int NREGS = 4;
    logic                rst, SCLK, CS, MOSI, MISO;
    logic [23:0]         status_in;
    logic [NREGS*24-1:0] regs_out;
    logic                wr_toggle;
    logic [6:0]          last_addr;
    logic                frame_err;
    int                  n_checks = 0, n_errors = 0;
    logic [23:0]         m_regs [NREGS];
    logic                m_tog, m_err;
    logic [6:0]          m_last;

    spi_slave_reg_ctrl #(.NREGS(NREGS)) dut (
        .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
        .status_in(status_in), .regs_out(regs_out),
        .wr_toggle(wr_toggle), .last_addr(last_addr)
`ifdef SPI_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );
`ifndef SPI_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 24'h000000;
        m_tog = 1'b0;
        m_last = 7'd0;
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NREGS*24-1:0] e;
        for (int i = 0; i < NREGS; i++) e[24*i +: 24] = m_regs[i];
        chk({tag, "_regs"}, regs_out, e);
        chk({tag, "_tog"}, wr_toggle, m_tog);
        chk({tag, "_last"}, last_addr, m_last);
        chk({tag, "_err"}, frame_err, m_err);
    endtask

    function automatic logic [23:0] status_word();
`ifdef SPI_FRAME_ERR_EN
        return {m_err, status_in[22:0]};
`else
        return status_in;
`endif
    endfunction

    task automatic frame(input logic [31:0] w, input int nedges);
        logic [6:0]  a;
        logic [23:0] exp_rd, got_rd;
        logic        idle_ok;
        a = w[30:24];
        exp_rd = 24'h000000;
        if (!w[31]) exp_rd = (a < NREGS) ? m_regs[a[1:0]] : (a == 7'h7F) ? status_word() : 24'h000000;
        got_rd = 24'h000000;
        idle_ok = 1'b1;
        CS = 1'b0;
        #5;
        for (int k = 1; k <= nedges; k++) begin
            MOSI = (k <= 32) ? w[32-k] : 1'($urandom_range(1));
            #5 SCLK = 1'b1;
            #5 SCLK = 1'b0;
            if (k >= 8 && k <= 31) got_rd[31-k] = MISO;
            else if (MISO !== 1'b0) idle_ok = 1'b0;
        end
        if (nedges >= 32) chk("miso_data", got_rd, exp_rd);
        chk("miso_idle", idle_ok, 1'b1);
        CS = 1'b1;
        #5;
        if (nedges >= 32 && w[31]) begin
            if (a < NREGS) begin
                m_regs[a[1:0]] = w[23:0];
                m_tog = ~m_tog;
                m_last = a;
            end
`ifdef SPI_FRAME_ERR_EN
            else if (a == 7'h7F) m_err = 1'b0;
`endif
        end
`ifdef SPI_FRAME_ERR_EN
        if (nedges != 0 && nedges != 32) m_err = 1'b1;
`endif
        check_outputs("frame");
    endtask

    task automatic reset_mid_frame();
        CS = 1'b0;
        #5;
        for (int k = 1; k <= 15; k++) begin
            MOSI = (k == 1) ? 1'b1 : 1'b0;
            #5 SCLK = 1'b1;
            #5 SCLK = 1'b0;
        end
        rst = 1'b0;
        #2;
        model_reset();
        check_outputs("midrst");
        chk("midrst_miso", MISO, 1'b0);
        CS = 1'b1;
        #3 rst = 1'b1;
        #5;
    endtask

    initial begin
        logic [6:0] a;
        int         r, ne;
        rst = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0; status_in = 24'h000000;
        #3 rst = 1'b0;
        #5;
        model_reset();
        check_outputs("reset");
        chk("reset_miso", MISO, 1'b0);
        rst = 1'b1;
        #5;
        frame(32'h00000000, 32);
        frame(32'h81ABCDEF, 32);
        frame(32'h01000000, 32);
        status_in = 24'h5A5A5A;
        frame(32'h7F000000, 32);
        frame(32'hFF123456, 32);
        frame(32'h90FFFFFF, 32);
        frame(32'h10000000, 32);
        frame(32'h82112233, 20);
        frame(32'h7F000000, 32);
        frame(32'h82112233, 32);
        frame(32'hFF000000, 32);
        frame(32'h7F000000, 32);
        frame(32'h03000000, 35);
        frame(32'hFF000000, 32);
        reset_mid_frame();
        frame(32'h80C0FFEE, 32);
        frame(32'h00000000, 32);
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(9));
            a = (r < 6) ? 7'($urandom_range(NREGS - 1)) : (r < 8) ? 7'h7F : 7'($urandom);
            ne = ($urandom_range(9) < 7) ? 32 : int'($urandom_range(36, 1));
            status_in = 24'($urandom);
            frame({1'($urandom_range(1)), a, 24'($urandom)}, ne);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
